// File: rtl/wave_pkg.sv
// wave_pkg: shared defaults and FSM state type for the waveform capture buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wave_pkg;

  localparam int DATA_W_DEF      = 10;
  localparam int DEPTH_DEF       = 640;
  localparam int ADDR_W_DEF      = 10;
  localparam int TRIG_LEVEL_DEF  = 320;
  localparam int AUTO_TRIG_N_DEF = 1280;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } cap_state_t;

  // True while a capture is armed or in progress.
  function automatic logic is_busy(input cap_state_t st);
    return (st == WAIT_TRIG) || (st == CAPTURE);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// capture_ram: DEPTH x DATA_W simple dual-port frame RAM, one write port, one registered read port.
// Latency: write lands on the clock edge; rd_data shows mem[rd_addr] one cycle after rd_addr.
// Backpressure: none; out-of-range read addresses return zero.
module capture_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; addresses past the last column read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_addr <= LAST_ADDR) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/wave_capture_buf.sv
// wave_capture_buf: arms on a pulse, waits for a rising crossing of TRIG_LEVEL, captures DEPTH samples and holds them.
// Latency: rd_data one cycle after rd_addr; frame_valid rises on the edge that writes the last sample.
// Backpressure: none; s_valid strobes are taken or ignored by state. Optional auto-trigger: `WAVE_CAPTURE_AUTO_TRIG_EN.
module wave_capture_buf
  import wave_pkg::*;
#(
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
  parameter int AUTO_TRIG_N = AUTO_TRIG_N_DEF,
`endif
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int TRIG_LEVEL = TRIG_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              arm,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic              busy,
  output logic              auto_trig
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] TRIG      = DATA_W'(TRIG_LEVEL);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
  logic              fv_q, fv_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              edge_hit;
  logic              start_cap;

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
  localparam int              CNT_W    = $clog2(AUTO_TRIG_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_TRIG_N - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_q, at_d;
  logic             auto_hit;
`endif

  // Next-state logic: arm overrides everything, then per-state trigger and capture handling.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    fv_d      = fv_q;
    wr_en     = 1'b0;
    wr_addr   = wr_ptr_q;
    edge_hit  = prev_ok_q && (prev_q < TRIG) && (s_data >= TRIG);
    start_cap = edge_hit;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    cnt_d     = cnt_q;
    at_d      = at_q;
    auto_hit  = (cnt_q == CNT_LAST);
    start_cap = edge_hit || auto_hit;
`endif

    if (arm) begin
      // Restart from scratch; a coincident sample is discarded entirely.
      state_d   = WAIT_TRIG;
      wr_ptr_d  = '0;
      prev_ok_d = 1'b0;
      fv_d      = 1'b0;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
      cnt_d     = '0;
      at_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        WAIT_TRIG: begin
          if (s_valid) begin
            prev_d    = s_data;
            prev_ok_d = 1'b1;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
            cnt_d     = cnt_q + 1'b1;
`endif
            if (start_cap) begin
              // Triggering sample becomes column 0.
              wr_en    = 1'b1;
              wr_addr  = '0;
              wr_ptr_d = ADDR_W'(1);
              state_d  = CAPTURE;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
              at_d     = !edge_hit;
`endif
            end
          end
        end
        CAPTURE: begin
          if (s_valid) begin
            wr_en = 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
              state_d = DONE;
              fv_d    = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE ignore the stream.
        end
      endcase
    end
  end

  // State and capture bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      fv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      fv_q      <= fv_d;
    end
  end

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
  // Forced-trigger sample counter and its status flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      at_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      at_q  <= at_d;
    end
  end

  assign auto_trig = at_q;
`else
  assign auto_trig = 1'b0;
`endif

  assign frame_valid = fv_q;
  assign busy        = is_busy(state_q);

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (s_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_wave_capture_buf.sv
// tb_wave_capture_buf: directed stimulus against a frame-level model of the capture buffer.
// Latency: model tracks one-cycle read latency and edge-exact frame_valid.
// Backpressure: n/a (stream source has none).
module tb_wave_capture_buf;

  localparam int DEPTH  = 640;
  localparam int AUTO_N = 1280;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       s_valid = 1'b0;
  logic       arm     = 1'b0;
  logic [9:0] s_data  = '0;
  logic [9:0] rd_addr = '0;
  logic [9:0] rd_data;
  logic       frame_valid;
  logic       busy;
  logic       auto_trig;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wave_capture_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .arm         (arm),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .busy        (busy),
    .auto_trig   (auto_trig)
  );

  // Frame-level model: phase 0 idle, 1 waiting, 2 capturing, 3 holding.
  int m_phase;
  int m_frame[$];
  int m_mem[DEPTH];
  bit m_fv, m_at, m_have_prev;
  int m_prev, m_cnt;
  bit exp_rd_vld;
  int exp_rd;
  bit chk_on = 1'b0;
  int ramp_v = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase     = 0;
    m_frame.delete();
    m_fv        = 1'b0;
    m_at        = 1'b0;
    m_have_prev = 1'b0;
    m_prev      = 0;
    m_cnt       = 0;
    exp_rd_vld  = 1'b1;
    exp_rd      = 0;
  endtask

  task automatic model_step(input bit a, input bit v, input int d, input int ad);
    bit hit, forced;
    exp_rd_vld = m_fv || (ad >= DEPTH);
    exp_rd     = (ad >= DEPTH) ? 0 : m_mem[ad];
    if (a) begin
      m_phase = 1;
      m_frame.delete();
      m_fv = 1'b0;
      m_at = 1'b0;
      m_have_prev = 1'b0;
      m_cnt = 0;
    end else if (m_phase == 1 && v) begin
      m_cnt++;
      hit    = m_have_prev && (m_prev < 320) && (d >= 320);
      forced = AUTO_EN && (m_cnt == AUTO_N);
      if (hit || forced) begin
        m_frame = {d};
        m_phase = 2;
        m_at    = !hit;
      end
      m_prev = d;
      m_have_prev = 1'b1;
    end else if (m_phase == 2 && v) begin
      m_frame.push_back(d);
      if (m_frame.size() == DEPTH) begin
        foreach (m_frame[i]) m_mem[i] = m_frame[i];
        m_fv    = 1'b1;
        m_phase = 3;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      check("auto_trig", 32'(auto_trig), 32'(m_at));
      if (exp_rd_vld) check("rd_data", 32'(rd_data), 32'(exp_rd));
    end
  end

  task automatic tick(input bit a, input bit v, input int d);
    arm     = a;
    s_valid = v;
    s_data  = 10'(d);
    @(posedge clk);
    if (rst_n) model_step(a, v, d, int'(rd_addr));
    else model_reset();
    #1;
  endtask

  task automatic stream(input int n, input int gap, input int step);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1, ramp_v);
      ramp_v = (ramp_v + step) % DEPTH;
      for (int g = 1; g < gap; g++) tick(1'b0, 1'b0, 0);
    end
  endtask

  task automatic read_at(input int addr, input int exp, input string name);
    rd_addr = 10'(addr);
    tick(1'b0, 1'b0, 0);
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = 10'(i);
      tick(1'b0, 1'b1, ramp_v);
      ramp_v = (ramp_v + 1) % DEPTH;
    end
  endtask

  initial begin
    model_reset();
    chk_on = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_auto_trig", 32'(auto_trig), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 400);   // IDLE ignores samples

    // 1: ramp every 4 clocks, trigger on 319->320
    tick(1'b1, 1'b0, 0);
    ramp_v = 0;
    stream(959, 4, 1);
    check("t1_fv_before_last", 32'(frame_valid), 32'd0);
    tick(1'b0, 1'b1, ramp_v);
    ramp_v = (ramp_v + 1) % DEPTH;
    check("t1_fv_on_319", 32'(frame_valid), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);

    // 2: keep streaming while holding, then read everything
    stream(100, 1, 1);
    read_all();
    read_at(0, 320, "t2_mem0");
    read_at(319, 639, "t2_mem319");
    read_at(320, 0, "t2_mem320");
    read_at(639, 319, "t2_mem639");
    read_at(700, 0, "t2_addr700");

    // 3: abort mid-capture, recapture on the next crossing
    rd_addr = '0;
    tick(1'b1, 1'b0, 0);
    ramp_v = 0;
    stream(421, 2, 1);
    tick(1'b1, 1'b0, 0);
    check("t3_abort_fv", 32'(frame_valid), 32'd0);
    check("t3_abort_busy", 32'(busy), 32'd1);
    stream(1178, 2, 1);
    check("t3_fv_before_last", 32'(frame_valid), 32'd0);
    tick(1'b0, 1'b1, ramp_v);
    ramp_v = (ramp_v + 1) % DEPTH;
    check("t3_fv_done", 32'(frame_valid), 32'd1);
    read_at(0, 320, "t3_mem0");
    read_at(100, 420, "t3_mem100");
    read_at(639, 319, "t3_mem639");

    // 4: arm with a coincident sample drops it; next sample only seeds
    rd_addr = '0;
    tick(1'b1, 1'b1, 100);
    tick(1'b0, 1'b1, 400);
    tick(1'b0, 1'b1, 200);
    tick(1'b0, 1'b1, 350);
    ramp_v = 351;
    stream(638, 1, 1);
    check("t4_fv_before_last", 32'(frame_valid), 32'd0);
    tick(1'b0, 1'b1, ramp_v);
    check("t4_fv_done", 32'(frame_valid), 32'd1);
    read_at(0, 350, "t4_mem0");
    read_at(1, 351, "t4_mem1");
    read_at(639, 349, "t4_mem639");

    // 5: constant input never crosses the level
    rd_addr = '0;
    tick(1'b1, 1'b0, 0);
    ramp_v = 500;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    stream(AUTO_N + 638, 1, 0);
    check("t5_fv_before_last", 32'(frame_valid), 32'd0);
    check("t5_at_before", 32'(auto_trig), 32'd0);
    tick(1'b0, 1'b1, 500);
    check("t5_fv_done", 32'(frame_valid), 32'd1);
    check("t5_auto_trig", 32'(auto_trig), 32'd1);
    read_all();
    read_at(0, 500, "t5_mem0");
    read_at(639, 500, "t5_mem639");
    tick(1'b1, 1'b0, 0);
    check("t5_at_clear", 32'(auto_trig), 32'd0);
`else
    stream(AUTO_N + 700, 1, 0);
    check("t5_busy_forever", 32'(busy), 32'd1);
    check("t5_fv_never", 32'(frame_valid), 32'd0);
    check("t5_auto_trig_off", 32'(auto_trig), 32'd0);
`endif

    // 6: async reset in the middle of a capture
    rd_addr = '0;
    tick(1'b1, 1'b0, 0);
    ramp_v = 300;
    stream(71, 1, 1);
    check("t6_capturing", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_fv", 32'(frame_valid), 32'd0);
    check("t6_rst_rd", 32'(rd_data), 32'd0);
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    ramp_v = 300;
    stream(30, 1, 1);
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_fv", 32'(frame_valid), 32'd0);
    tick(1'b1, 1'b0, 0);
    ramp_v = 0;
    stream(326, 1, 1);
    check("t6_rearm_busy", 32'(busy), 32'd1);
    check("t6_rearm_fv", 32'(frame_valid), 32'd0);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
